au_smq_iter: RTL and testbench

- Parametrised next-generation arithmetic unit (AU) for the Kalman datapath, operating on sign-magnitude fixed point (1 sign bit, W-1 magnitude bits, FRAC fraction bits).
- Keeps the 1-cycle ADD/SUB/MUL operations of the current AU.
- Adds iterative restoring division, immediate-operand ops, ABS, saturation, and overflow/divide-by-zero flags.
- Sits under the datapath controller and uses the same start/busy/done handshake.

---
 rtl/au_smq_iter.sv | 204 ++++++++++++++++++++
 tb/tb_au_smq_iter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/au_smq_iter.sv
// Sign-magnitude fixed-point arithmetic unit: 1-cycle ADD/SUB/MUL/ADDI/MULI/ABS and iterative restoring DIV.
// Define AU_ROUND_EN for round-half-away-from-zero on MUL/MULI/DIV; truncation toward zero otherwise.
`timescale 1ns/1ps
module au_smq_iter #(
    parameter int W    = 24,
    parameter int FRAC = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] R,
    input  logic [W-1:0] S,
    input  logic [W-1:0] I,
    input  logic [2:0]   ctl_d,
    output logic [W-1:0] result,
    output logic         done,
    output logic         busy,
    output logic         ovf,
    output logic         dz
);
    localparam int M = W - 1;
    localparam int N = M + FRAC;
`ifdef AU_ROUND_EN
    localparam int NIT = N + 1;
`else
    localparam int NIT = N;
`endif
    localparam int CW = $clog2(NIT + 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam logic [2:0] OP_MULI = 3'b101;
    localparam logic [2:0] OP_ABS  = 3'b110;

    localparam logic [M-1:0] MAX_MAG = {M{1'b1}};

    typedef enum logic [1:0] {IDLE, EXEC, DIV_IT, FIN} state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   a_reg, b_reg;
    logic [2:0]     op_reg;
    logic [NIT-1:0] dvd_reg, q_reg;
    logic [M-1:0]   rem_reg;
    logic [CW-1:0]  cnt_reg;
    logic [W-1:0]   result_reg;
    logic           done_reg, busy_reg, ovf_reg, dz_reg;

    logic [M-1:0]   ma, mb;
    logic           sa, sb;
    logic [M:0]     sum_mag;
    logic [2*M-1:0] prod, mshift;
    logic [M-1:0]   s_mag;
    logic           s_sign, s_ovf, s_dz;
    logic [M:0]     rem_shift;
    logic           q_bit;
    logic [M-1:0]   rem_next;
    logic [NIT-1:0] qf;
    logic [M-1:0]   d_mag;
    logic           d_ovf;

    assign ma = a_reg[M-1:0];
    assign mb = b_reg[M-1:0];
    // Signs normalised so -0 behaves as +0; SUB flips the sign of the second operand.
    assign sa = a_reg[M] & (|ma);
    assign sb = (b_reg[M] ^ (op_reg == OP_SUB)) & (|mb);
    assign sum_mag = {1'b0, ma} + {1'b0, mb};
    assign prod = {{M{1'b0}}, ma} * {{M{1'b0}}, mb};
`ifdef AU_ROUND_EN
    assign mshift = (prod >> FRAC) + {{(2*M-1){1'b0}}, prod[FRAC-1]};
`else
    assign mshift = prod >> FRAC;
`endif

    always_comb begin
        s_mag  = '0;
        s_sign = 1'b0;
        s_ovf  = 1'b0;
        s_dz   = 1'b0;
        case (op_reg)
            OP_ADD, OP_SUB, OP_ADDI: begin
                if (sa == sb) begin
                    s_sign = sa;
                    if (sum_mag[M]) begin
                        s_mag = MAX_MAG;
                        s_ovf = 1'b1;
                    end else begin
                        s_mag = sum_mag[M-1:0];
                    end
                end else if (ma >= mb) begin
                    s_sign = sa;
                    s_mag  = ma - mb;
                end else begin
                    s_sign = sb;
                    s_mag  = mb - ma;
                end
            end
            OP_MUL, OP_MULI: begin
                s_sign = sa ^ sb;
                if (|mshift[2*M-1:M]) begin
                    s_mag = MAX_MAG;
                    s_ovf = 1'b1;
                end else begin
                    s_mag = mshift[M-1:0];
                end
            end
            OP_DIV: begin
                // Only reached with a zero divisor; raw signs are used so -x / -0 gives +max.
                s_sign = a_reg[M] ^ b_reg[M];
                s_mag  = MAX_MAG;
                s_dz   = 1'b1;
            end
            OP_ABS: s_mag = ma;
            default: s_mag = '0;
        endcase
    end

    // One restoring step: bring in the next dividend bit and subtract if it fits.
    assign rem_shift = {rem_reg, dvd_reg[NIT-1]};
    assign q_bit     = (rem_shift >= {1'b0, mb});
    assign rem_next  = q_bit ? M'(rem_shift - {1'b0, mb}) : rem_shift[M-1:0];

`ifdef AU_ROUND_EN
    assign qf = (q_reg >> 1) + {{(NIT-1){1'b0}}, q_reg[0]};
`else
    assign qf = q_reg;
`endif
    assign d_ovf = |qf[NIT-1:M];
    assign d_mag = d_ovf ? MAX_MAG : qf[M-1:0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = (ctl_d == OP_DIV && |S[M-1:0]) ? DIV_IT : EXEC;
            EXEC:    state_next = IDLE;
            DIV_IT:  if (cnt_reg == CW'(NIT - 1)) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            dvd_reg    <= '0;
            q_reg      <= '0;
            rem_reg    <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            dz_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: if (start) begin
                    a_reg    <= R;
                    b_reg    <= (ctl_d == OP_ADDI || ctl_d == OP_MULI) ? I : S;
                    op_reg   <= ctl_d;
                    dvd_reg  <= {R[M-1:0], {(NIT-M){1'b0}}};
                    q_reg    <= '0;
                    rem_reg  <= '0;
                    cnt_reg  <= '0;
                    busy_reg <= 1'b1;
                    ovf_reg  <= 1'b0;
                    dz_reg   <= 1'b0;
                end
                EXEC: begin
                    result_reg <= {s_sign & (|s_mag), s_mag};
                    ovf_reg    <= s_ovf;
                    dz_reg     <= s_dz;
                    done_reg   <= 1'b1;
                    busy_reg   <= 1'b0;
                end
                DIV_IT: begin
                    dvd_reg <= {dvd_reg[NIT-2:0], 1'b0};
                    rem_reg <= rem_next;
                    q_reg   <= {q_reg[NIT-2:0], q_bit};
                    cnt_reg <= cnt_reg + CW'(1);
                end
                FIN: begin
                    result_reg <= {(a_reg[M] ^ b_reg[M]) & (|d_mag), d_mag};
                    ovf_reg    <= d_ovf;
                    done_reg   <= 1'b1;
                    busy_reg   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign result = result_reg;
    assign done   = done_reg;
    assign busy   = busy_reg;
    assign ovf    = ovf_reg;
    assign dz     = dz_reg;
endmodule

// File: tb/tb_au_smq_iter.sv
// Scoreboard bench for au_smq_iter: stimulus pushes expected completions, a negedge monitor checks each done.
`timescale 1ns/1ps
module tb_au_smq_iter;
    localparam int W = 24;
    localparam int FRAC = 14;
`ifdef AU_ROUND_EN
    localparam int           DIV_LAT = 39;
    localparam logic [23:0]  DIV23   = 24'h002AAB;
    localparam logic [23:0]  MUL_RND = 24'h000001;
`else
    localparam int           DIV_LAT = 38;
    localparam logic [23:0]  DIV23   = 24'h002AAA;
    localparam logic [23:0]  MUL_RND = 24'h000000;
`endif

    logic         clk = 1'b0;
    logic         rst_n, start;
    logic [W-1:0] R, S, I, result;
    logic [2:0]   ctl_d;
    logic         done, busy, ovf, dz;

    au_smq_iter #(.W(W), .FRAC(FRAC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .R(R), .S(S), .I(I), .ctl_d(ctl_d),
        .result(result), .done(done), .busy(busy), .ovf(ovf), .dz(dz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] tag;
        logic [23:0] res;
        logic        ovf;
        logic        dz;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk($sformatf("%0s_result", e.tag), 32'(result), 32'(e.res));
                chk($sformatf("%0s_ovf", e.tag), 32'(ovf), 32'(e.ovf));
                chk($sformatf("%0s_dz", e.tag), 32'(dz), 32'(e.dz));
                chk($sformatf("%0s_done_cycle", e.tag), 32'(cyc), 32'(e.cyc));
                chk($sformatf("%0s_busy_at_done", e.tag), 32'(busy), 32'd0);
                $display("txn %0s result=%h ovf=%0b dz=%0b cycle=%0d", e.tag, result, ovf, dz, cyc);
            end
        end
    end

    task automatic drain();
        for (int n = 0; n < 80; n++) begin
            @(negedge clk); #1;
            if (sb_q.size() == 0) return;
        end
        chk("drain_timeout", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    // Called just after a negedge; the following posedge accepts the op.
    task automatic launch(input logic [2:0] op, input logic [23:0] r, s, i,
                          input logic [23:0] er, input logic eo, ed, input int lat,
                          input logic [63:0] tag);
        R = r; S = s; I = i; ctl_d = op; start = 1'b1;
        sb_q.push_back('{tag, er, eo, ed, cyc + 1 + lat});
        @(negedge clk); #1;
        start = 1'b0;
        R = 24'($urandom); S = 24'($urandom); I = 24'($urandom); ctl_d = 3'($urandom);
        chk($sformatf("%0s_busy_running", tag), 32'(busy), 32'd1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [23:0] r, s, i,
                         input logic [23:0] er, input logic eo, ed, input int lat,
                         input logic [63:0] tag);
        launch(op, r, s, i, er, eo, ed, lat, tag);
        drain();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; R = '0; S = '0; I = '0; ctl_d = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_dz", 32'(dz), 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        issue(3'b000, 24'h00C000, 24'h808000, 24'h0,      24'h004000, 0, 0, 1,       "ADD");
        issue(3'b001, 24'h008000, 24'h008000, 24'h0,      24'h000000, 0, 0, 1,       "SUBZ");
        issue(3'b000, 24'h004000, 24'h80C000, 24'h0,      24'h808000, 0, 0, 1,       "ADDNEG");
        issue(3'b000, 24'h800000, 24'h000000, 24'h0,      24'h000000, 0, 0, 1,       "ADDM0");
        issue(3'b010, 24'h400000, 24'hC00000, 24'h0,      24'hFFFFFF, 1, 0, 1,       "MULSAT");
        issue(3'b010, 24'h006000, 24'h808000, 24'h0,      24'h80C000, 0, 0, 1,       "MUL");
        issue(3'b010, 24'h000001, 24'h002000, 24'h0,      MUL_RND,    0, 0, 1,       "MULRND");
        issue(3'b101, 24'h006000, 24'h000000, 24'h008000, 24'h00C000, 0, 0, 1,       "MULI");
        issue(3'b011, 24'h008000, 24'h00C000, 24'h0,      DIV23,      0, 0, DIV_LAT, "DIV");
        issue(3'b011, 24'h814000, 24'h800000, 24'h0,      24'h7FFFFF, 0, 1, 1,       "DIVZ");
        issue(3'b100, 24'h7FC000, 24'h000000, 24'h7FC000, 24'h7FFFFF, 1, 0, 1,       "ADDI");
        issue(3'b110, 24'h80C000, 24'h0,      24'h0,      24'h00C000, 0, 0, 1,       "ABS");
        issue(3'b111, 24'h123456, 24'h654321, 24'h111111, 24'h000000, 0, 0, 1,       "RSV");

        // Starts pulsed while DIV iterates must be ignored.
        launch(3'b011, 24'h008000, 24'h00C000, 24'h0, DIV23, 0, 0, DIV_LAT, "DIVIGN");
        for (int n = 2; n < 80; n++) begin
            @(negedge clk); #1;
            if (n == 3 || n == 20) begin
                R = 24'h004000; S = 24'h004000; ctl_d = 3'b000; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (sb_q.size() == 0) break;
        end
        start = 1'b0;
        chk("divign_pending", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        repeat (4) @(negedge clk);
        #1;

        // Reset mid-DIV aborts the op without a done pulse.
        launch(3'b011, 24'h008000, 24'h00C000, 24'h0, DIV23, 0, 0, DIV_LAT, "DIVRST");
        repeat (9) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        chk("abort_dz", 32'(dz), 32'd0);
        sb_q.delete();
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        issue(3'b000, 24'h004000, 24'h004000, 24'h0, 24'h008000, 0, 0, 1, "ADDPOST");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
